// File: rtl/hline_zbuff_pkg.sv
// -----------------------------------------------------------------------------
// hline_zbuff_pkg
// Shared definitions for the horizontal-line z-buffered span controller:
//   - state_t     : controller state encoding (0..8, also exported on curr_state)
//   - ZF_*        : depth-test function codes driven on zfunc
//   - BYTES_PER_WORD : byte stride of one z or colour word in memory
// -----------------------------------------------------------------------------
package hline_zbuff_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INIT       = 4'd1,
    LOOP_START = 4'd2,
    LOAD_Z     = 4'd3,
    LOAD_F     = 4'd4,
    INTERP     = 4'd5,
    WR_Z       = 4'd6,
    WR_F       = 4'd7,
    DONE       = 4'd8
  } state_t;

  localparam logic [1:0] ZF_LESS    = 2'd0;
  localparam logic [1:0] ZF_LEQUAL  = 2'd1;
  localparam logic [1:0] ZF_GREATER = 2'd2;
  localparam logic [1:0] ZF_ALWAYS  = 2'd3;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/hline_zbuff_ctrl_zinterp_step.sv
// -----------------------------------------------------------------------------
// zinterp_step
// One Bresenham-style z interpolation step (purely combinational).
// Ports:
//   zsum, error  : current interpolated z and error accumulator
//   slope        : signed integer z step per pixel
//   rem          : unsigned error increment per pixel
//   dx           : span length, the error threshold
//   zsum_next    : z for the next pixel (wraps modulo 2^DATA_W)
//   error_next   : error accumulator for the next pixel
// -----------------------------------------------------------------------------
module zinterp_step #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic [DATA_W-1:0] zsum,
  input  logic [DATA_W-1:0] error,
  input  logic [DATA_W-1:0] slope,
  input  logic [DATA_W-1:0] rem,
  input  logic [CNT_W-1:0]  dx,
  output logic [DATA_W-1:0] zsum_next,
  output logic [DATA_W-1:0] error_next
);

  logic [DATA_W:0]   e_sum;
  logic [DATA_W:0]   dx_ext;
  logic [DATA_W:0]   e_diff;
  logic [DATA_W-1:0] sgn;
  logic              carry;

  // NOTE: every signal written here gets a value on every path before any
  // conditional use, so no latch can be inferred from this block.
  always_comb begin
    // One extra bit so error+rem cannot overflow before the threshold compare.
    e_sum  = {1'b0, error} + {1'b0, rem};
    dx_ext = {{(DATA_W+1-CNT_W){1'b0}}, dx};
    e_diff = e_sum - dx_ext;
    carry  = (e_sum > dx_ext);
    // The carry pushes z one more unit in the slope's own direction.
    sgn    = slope[DATA_W-1] ? {DATA_W{1'b1}} : DATA_W'(1);
    if (carry) begin
      zsum_next  = zsum + slope + sgn;
      error_next = e_diff[DATA_W-1:0];
    end else begin
      zsum_next  = zsum + slope;
      error_next = e_sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/hline_zbuff_ctrl.sv
// -----------------------------------------------------------------------------
// hline_zbuff_ctrl
// Horizontal-line z-buffered span controller. A span of dx pixels is handled
// in bursts of at most BURST_MAX words: read z segment, read colour segment,
// interpolate/depth-test one pixel per cycle into the output FIFOs, then write
// z and colour segments back.
//
// Optional feature (macro HLINE_ZBUFF_STATS_EN): adds output pass_cnt, the
// saturating count of depth-test passes in the current span.
//
// Ports:
//   clk, nreset            : clock, synchronous active-low reset
//   start, abort           : span start (IDLE/DONE only), synchronous abort
//   fb_addr, zbuff_addr    : byte addresses of the first pixel
//   dx, z1, slope, rem, err: span length and z interpolation parameters
//   rgbx, zfunc, zwrite_en : span colour, depth function, z write mask
//   z_fifo_in, f_fifo_in   : heads of the z / colour input FIFOs
//   axi_done               : one-cycle burst completion pulse
//   rd_req, wr_req, addr, burst_len : burst request interface
//   axi_bus_to_z/f_fifo    : route read data into z / colour FIFO
//   read_in_fifos, write_out_fifos  : pop inputs / push outputs per pixel
//   read_z/f_out_fifo      : drain output FIFOs to the bus
//   z_out, f_out, pix_pass : merged words and depth-test result
//   busy, done, curr_state : status
// -----------------------------------------------------------------------------
module hline_zbuff_ctrl
  import hline_zbuff_pkg::*;
#(
  parameter int BURST_MAX = 256,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] fb_addr,
  input  logic [ADDR_W-1:0] zbuff_addr,
  input  logic [CNT_W-1:0]  dx,
  input  logic [DATA_W-1:0] z1,
  input  logic [DATA_W-1:0] slope,
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] err,
  input  logic [DATA_W-1:0] rgbx,
  input  logic [1:0]        zfunc,
  input  logic              zwrite_en,
  input  logic [DATA_W-1:0] z_fifo_in,
  input  logic [DATA_W-1:0] f_fifo_in,
  input  logic              axi_done,
  output logic              rd_req,
  output logic              wr_req,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  burst_len,
  output logic              axi_bus_to_z_fifo,
  output logic              axi_bus_to_f_fifo,
  output logic              read_in_fifos,
  output logic              write_out_fifos,
  output logic              read_z_out_fifo,
  output logic              read_f_out_fifo,
  output logic [DATA_W-1:0] z_out,
  output logic [DATA_W-1:0] f_out,
  output logic              pix_pass,
  output logic              busy,
  output logic              done,
  output logic [3:0]        curr_state
`ifdef HLINE_ZBUFF_STATS_EN
  ,
  output logic [CNT_W-1:0]  pass_cnt
`endif
);

  state_t            state, state_next;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  xcnt;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  len_sel;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] zsum;
  logic [DATA_W-1:0] err_acc;
  logic [DATA_W-1:0] zsum_next;
  logic [DATA_W-1:0] err_next;
  logic              pass;
  logic              pixel_go;

  zinterp_step #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_step (
    .zsum       (zsum),
    .error      (err_acc),
    .slope      (slope),
    .rem        (rem),
    .dx         (dx),
    .zsum_next  (zsum_next),
    .error_next (err_next)
  );

  // Last burst of a span may be shorter than BURST_MAX.
  assign len_sel  = (remaining > CNT_W'(BURST_MAX)) ? CNT_W'(BURST_MAX) : remaining;
  assign pixel_go = (state == INTERP) && (xcnt != '0);

  // Depth test and merge are combinational on the FIFO heads.
  always_comb begin
    pass = 1'b0;
    case (zfunc)
      ZF_LESS:    pass = (zsum <  z_fifo_in);
      ZF_LEQUAL:  pass = (zsum <= z_fifo_in);
      ZF_GREATER: pass = (zsum >  z_fifo_in);
      default:    pass = 1'b1;
    endcase
  end

  assign z_out    = (pass && zwrite_en) ? zsum : z_fifo_in;
  assign f_out    = pass ? rgbx : f_fifo_in;
  assign pix_pass = pass;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  // Next state and decoded outputs.
  always_comb begin
    state_next        = state;
    rd_req            = 1'b0;
    wr_req            = 1'b0;
    addr              = '0;
    axi_bus_to_z_fifo = 1'b0;
    axi_bus_to_f_fifo = 1'b0;
    read_in_fifos     = 1'b0;
    write_out_fifos   = 1'b0;
    read_z_out_fifo   = 1'b0;
    read_f_out_fifo   = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = INIT;
      end
      INIT:       state_next = LOOP_START;
      LOOP_START: state_next = (remaining == '0) ? DONE : LOAD_Z;
      LOAD_Z: begin
        rd_req            = 1'b1;
        axi_bus_to_z_fifo = 1'b1;
        addr              = zbuff_addr + offset;
        if (axi_done) state_next = LOAD_F;
      end
      LOAD_F: begin
        rd_req            = 1'b1;
        axi_bus_to_f_fifo = 1'b1;
        addr              = fb_addr + offset;
        if (axi_done) state_next = INTERP;
      end
      INTERP: begin
        read_in_fifos   = pixel_go;
        write_out_fifos = pixel_go;
        if (xcnt == '0) state_next = WR_Z;
      end
      WR_Z: begin
        wr_req          = 1'b1;
        read_z_out_fifo = 1'b1;
        addr            = zbuff_addr + offset;
        if (axi_done) state_next = WR_F;
      end
      WR_F: begin
        wr_req          = 1'b1;
        read_f_out_fifo = 1'b1;
        addr            = fb_addr + offset;
        if (axi_done) state_next = LOOP_START;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_next = INIT;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Span datapath: counters, burst offset and interpolation state.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      remaining <= '0;
      xcnt      <= '0;
      len       <= '0;
      offset    <= '0;
      zsum      <= '0;
      err_acc   <= '0;
    end else begin
      case (state)
        INIT: begin
          remaining <= dx;
          zsum      <= z1;
          err_acc   <= err;
          offset    <= '0;
        end
        LOOP_START: begin
          if (remaining != '0) begin
            len       <= len_sel;
            remaining <= remaining - len_sel;
            xcnt      <= len_sel;
          end
        end
        INTERP: begin
          if (pixel_go) begin
            xcnt    <= xcnt - CNT_W'(1);
            zsum    <= zsum_next;
            err_acc <= err_next;
          end
        end
        WR_F: begin
          if (axi_done) offset <= offset + ADDR_W'(len) * ADDR_W'(BYTES_PER_WORD);
        end
        default: ;
      endcase
    end
  end

  assign burst_len  = len;
  assign curr_state = state;

`ifdef HLINE_ZBUFF_STATS_EN
  logic [CNT_W-1:0] pass_cnt_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      pass_cnt_q <= '0;
    end else if (state == INIT) begin
      pass_cnt_q <= '0;
    end else if (pixel_go && pass && (pass_cnt_q != {CNT_W{1'b1}})) begin
      pass_cnt_q <= pass_cnt_q + CNT_W'(1);
    end
  end

  assign pass_cnt = pass_cnt_q;
`endif

endmodule

// File: tb/tb_hline_zbuff_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hline_zbuff_ctrl
// Directed bench for hline_zbuff_ctrl with default parameters (BURST_MAX=256).
// A bench-side responder serves each burst with a delayed axi_done pulse;
// per-pixel FIFO heads and expected merged words come from small tables.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hline_zbuff_ctrl;
  import hline_zbuff_pkg::*;

  localparam logic [31:0] ZB = 32'h1000_0000;
  localparam logic [31:0] FB = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        nreset, start, abort, zwrite_en, axi_done;
  logic [31:0] fb_addr, zbuff_addr, z1, slope, rem, err, rgbx, z_fifo_in, f_fifo_in;
  logic [15:0] dx;
  logic [1:0]  zfunc;
  logic        rd_req, wr_req, axi_bus_to_z_fifo, axi_bus_to_f_fifo;
  logic        read_in_fifos, write_out_fifos, read_z_out_fifo, read_f_out_fifo;
  logic        pix_pass, busy, done;
  logic [31:0] addr, z_out, f_out;
  logic [15:0] burst_len;
  logic [3:0]  curr_state;
`ifdef HLINE_ZBUFF_STATS_EN
  logic [15:0] pass_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Per-pixel stimulus and expectations for single-burst spans.
  logic [31:0] zin [16];
  logic [31:0] fin [16];
  logic [31:0] ez  [16];
  logic [31:0] ef  [16];
  logic        ep  [16];

  always #5 clk = ~clk;

  hline_zbuff_ctrl dut (
    .clk(clk), .nreset(nreset), .start(start), .abort(abort),
    .fb_addr(fb_addr), .zbuff_addr(zbuff_addr), .dx(dx), .z1(z1),
    .slope(slope), .rem(rem), .err(err), .rgbx(rgbx), .zfunc(zfunc),
    .zwrite_en(zwrite_en), .z_fifo_in(z_fifo_in), .f_fifo_in(f_fifo_in),
    .axi_done(axi_done), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .burst_len(burst_len), .axi_bus_to_z_fifo(axi_bus_to_z_fifo),
    .axi_bus_to_f_fifo(axi_bus_to_f_fifo), .read_in_fifos(read_in_fifos),
    .write_out_fifos(write_out_fifos), .read_z_out_fifo(read_z_out_fifo),
    .read_f_out_fifo(read_f_out_fifo), .z_out(z_out), .f_out(f_out),
    .pix_pass(pix_pass), .busy(busy), .done(done), .curr_state(curr_state)
`ifdef HLINE_ZBUFF_STATS_EN
    , .pass_cnt(pass_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {rd_req, wr_req, to_z, to_f, rd_z_out, rd_f_out} expected in each bus state.
  function automatic logic [5:0] bus_strobes(input state_t st);
    case (st)
      LOAD_Z:  return 6'b101000;
      LOAD_F:  return 6'b100100;
      WR_Z:    return 6'b010010;
      WR_F:    return 6'b010001;
      default: return 6'b000000;
    endcase
  endfunction

  // Wait (bounded) for a bus state, check its request, then answer with axi_done.
  task automatic serve(input state_t st, input logic [31:0] a, input logic [15:0] l,
                       input string tag);
    int n = 0;
    while (curr_state !== st && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_state"}, curr_state, st);
    check({tag, "_addr"}, addr, a);
    check({tag, "_len"}, burst_len, l);
    check({tag, "_strb"}, {rd_req, wr_req, axi_bus_to_z_fifo, axi_bus_to_f_fifo,
                           read_z_out_fifo, read_f_out_fifo, busy},
          {bus_strobes(st), 1'b1});
    tick();
    tick();
    axi_done = 1'b1;
    tick();
    axi_done = 1'b0;
  endtask

  // Drive table-driven FIFO heads for n pixels and check the merged words.
  task automatic pixels(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      z_fifo_in = zin[i];
      f_fifo_in = fin[i];
      #1;
      check($sformatf("%s_z%0d", tag, i), z_out, ez[i]);
      check($sformatf("%s_f%0d", tag, i), f_out, ef[i]);
      check($sformatf("%s_p%0d", tag, i), pix_pass, ep[i]);
      check($sformatf("%s_fifo%0d", tag, i), {read_in_fifos, write_out_fifos}, 2'b11);
      tick();
    end
    check({tag, "_xcnt0"}, {curr_state, read_in_fifos, write_out_fifos}, {INTERP, 2'b00});
  endtask

  // Full single-burst span starting from IDLE or DONE.
  task automatic run_span(input int n, input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    serve(LOAD_Z, ZB, 16'(n), {tag, "_rz"});
    serve(LOAD_F, FB, 16'(n), {tag, "_rf"});
    pixels(n, tag);
    serve(WR_Z, ZB, 16'(n), {tag, "_wz"});
    serve(WR_F, FB, 16'(n), {tag, "_wf"});
    tick();
    check({tag, "_done"}, {curr_state, done, busy}, {DONE, 2'b10});
  endtask

  // Multi-burst span with slope=1, ALWAYS: z_out equals the pixel index.
  task automatic run_multi(input int n, input string tag);
    int left = n;
    int b = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (left > 0) begin
      int l = (left > 256) ? 256 : left;
      serve(LOAD_Z, ZB + 32'(b * 1024), 16'(l), $sformatf("%s_rz%0d", tag, b));
      serve(LOAD_F, FB + 32'(b * 1024), 16'(l), $sformatf("%s_rf%0d", tag, b));
      for (int i = 0; i < l; i++) begin
        if (i == 0 || i == l - 1)
          check($sformatf("%s_z%0d_%0d", tag, b, i), z_out, 32'(b * 256 + i));
        tick();
      end
      check($sformatf("%s_end%0d", tag, b), write_out_fifos, 1'b0);
      serve(WR_Z, ZB + 32'(b * 1024), 16'(l), $sformatf("%s_wz%0d", tag, b));
      serve(WR_F, FB + 32'(b * 1024), 16'(l), $sformatf("%s_wf%0d", tag, b));
      left -= l;
      b++;
    end
    tick();
    check({tag, "_done"}, {curr_state, done}, {DONE, 1'b1});
  endtask

  initial begin
    nreset = 1'b0; start = 1'b0; abort = 1'b0; axi_done = 1'b0;
    fb_addr = FB; zbuff_addr = ZB; dx = '0; z1 = '0; slope = '0;
    rem = '0; err = '0; rgbx = 32'hAABB_CCDD; zfunc = ZF_LESS; zwrite_en = 1'b1;
    z_fifo_in = '0; f_fifo_in = '0;
    tick(); tick(); tick();

    // Reset state.
    check("rst_state", curr_state, IDLE);
    check("rst_ctl", {rd_req, wr_req, axi_bus_to_z_fifo, axi_bus_to_f_fifo, read_in_fifos,
                      write_out_fifos, read_z_out_fifo, read_f_out_fifo, busy, done}, 10'b0);
    check("rst_addr", addr, 32'h0);
    check("rst_len", burst_len, 16'h0);
    nreset = 1'b1;
    tick();
    check("idle_state", curr_state, IDLE);

    // 1: dx=10, slope 5, LESS against 200: z 100..145, all pass.
    dx = 16'd10; z1 = 32'd100; slope = 32'd5; rem = '0; err = '0; zfunc = ZF_LESS;
    for (int i = 0; i < 10; i++) begin
      zin[i] = 32'd200; fin[i] = 32'h0000_1111;
      ez[i] = 32'(100 + 5 * i); ef[i] = 32'hAABB_CCDD; ep[i] = 1'b1;
    end
    run_span(10, "t1");

    // 2: dx=600 -> bursts 256/256/88; dx=257 -> final burst of one word.
    z1 = '0; slope = 32'd1; zfunc = ZF_ALWAYS; z_fifo_in = 32'd7;
    dx = 16'd600;
    run_multi(600, "t2");
    dx = 16'd257;
    run_multi(257, "t2b");

    // 3: negative slope with carry on the first pixel: steps -4 then -3.
    dx = 16'd2; z1 = 32'd1000; slope = 32'hFFFF_FFFD; rem = 32'd1; err = 32'd2;
    zin[0] = 32'd5000; zin[1] = 32'd5000; fin[0] = 32'h0; fin[1] = 32'h0;
    ez[0] = 32'd1000; ez[1] = 32'd996;
    ef[0] = 32'hAABB_CCDD; ef[1] = 32'hAABB_CCDD; ep[0] = 1'b1; ep[1] = 1'b1;
    run_span(2, "t3");
    // Same slope, dx=3: carry lands on the second pixel (1000, 997, 993).
    dx = 16'd3;
    zin[2] = 32'd5000; fin[2] = 32'h0; ef[2] = 32'hAABB_CCDD; ep[2] = 1'b1;
    ez[0] = 32'd1000; ez[1] = 32'd997; ez[2] = 32'd993;
    run_span(3, "t3b");

    // 4: GREATER with z write masked; second pixel fails the test.
    dx = 16'd2; z1 = 32'd500; slope = '0; rem = '0; err = '0;
    zfunc = ZF_GREATER; zwrite_en = 1'b0;
    zin[0] = 32'd100; fin[0] = 32'h1111_1111; ez[0] = 32'd100; ef[0] = 32'hAABB_CCDD; ep[0] = 1'b1;
    zin[1] = 32'd600; fin[1] = 32'h2222_2222; ez[1] = 32'd600; ef[1] = 32'h2222_2222; ep[1] = 1'b0;
    run_span(2, "t4");
`ifdef HLINE_ZBUFF_STATS_EN
    check("t4_pass_cnt", pass_cnt, 16'd1);
`endif
    // LEQUAL boundary: equal passes, one-below fails.
    z1 = 32'd300; zfunc = ZF_LEQUAL; zwrite_en = 1'b1;
    zin[0] = 32'd300; fin[0] = 32'h3; ez[0] = 32'd300; ef[0] = 32'hAABB_CCDD; ep[0] = 1'b1;
    zin[1] = 32'd299; fin[1] = 32'h4; ez[1] = 32'd299; ef[1] = 32'h4;          ep[1] = 1'b0;
    run_span(2, "t4b");

    // 5: empty span: INIT, LOOP_START, DONE with no requests.
    dx = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_init", {curr_state, rd_req, wr_req}, {INIT, 2'b00});
    tick();
    check("t5_loop", {curr_state, rd_req, wr_req}, {LOOP_START, 2'b00});
    tick();
    check("t5_done", {curr_state, rd_req, wr_req, done}, {DONE, 3'b001});

    // 6: abort in INTERP with 100 pixels left, then a normal span.
    dx = 16'd150; z1 = '0; slope = 32'd1; zfunc = ZF_ALWAYS; z_fifo_in = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    serve(LOAD_Z, ZB, 16'd150, "t6_rz");
    serve(LOAD_F, FB, 16'd150, "t6_rf");
    for (int i = 0; i < 50; i++) tick();
    check("t6_mid", {curr_state, write_out_fifos, z_out}, {INTERP, 1'b1, 32'd50});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort", {curr_state, rd_req, wr_req, axi_bus_to_z_fifo, axi_bus_to_f_fifo,
                       read_in_fifos, write_out_fifos, read_z_out_fifo, read_f_out_fifo, busy},
          {IDLE, 9'b0});
    dx = 16'd4;
    for (int i = 0; i < 4; i++) begin
      zin[i] = 32'd9; fin[i] = 32'h0; ez[i] = 32'(i); ef[i] = 32'hAABB_CCDD; ep[i] = 1'b1;
    end
    run_span(4, "t6_after");
`ifdef HLINE_ZBUFF_STATS_EN
    check("t6_pass_cnt", pass_cnt, 16'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
